// File: rtl/ram8_streamer_pkg.sv
// ============================================================================
// Module  : ram8_streamer_pkg
// Brief   : Shared sizes and FSM state encoding for the RAM8 streamer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram8_streamer_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int ADDR_W    = $clog2(DEPTH_DEF);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] SUM  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SEND = SEND,
        S_SUM  = SUM,
        S_DONE = DONE
    } state_t;

endpackage : ram8_streamer_pkg

`default_nettype wire

// File: rtl/ram8_stream_fsm.sv
// ============================================================================
// Module  : ram8_stream_fsm
// Brief   : Dump sequencer: state, read pointer, valid/ready output register,
//           last/done flags; optional checksum word (RAM8_STREAMER_CHECKSUM_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram8_stream_fsm
    import ram8_streamer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic                        dout_ready_i,
    input  logic [WIDTH-1:0]            rd_data_i,
    output logic [$clog2(DEPTH)-1:0]    rd_addr_o,
    output logic [WIDTH-1:0]            dout_o,
    output logic                        dout_valid_o,
    output logic                        dout_last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              PTR_W   = AW + 1;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LST = PTR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [WIDTH-1:0]   dout_q,  dout_d;
    logic               valid_q, valid_d;
    logic               last_q,  last_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
`ifdef RAM8_STREAMER_CHECKSUM_EN
    logic [WIDTH-1:0]   sum_q,   sum_d;
`endif

    logic               hs;
    assign hs        = valid_q & dout_ready_i;
    assign rd_addr_o = ptr_q[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RAM8_STREAMER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RAM8_STREAMER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef RAM8_STREAMER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    dout_d  = rd_data_i;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    ptr_d   = PTR_W'(1);
                    state_d = S_SEND;
`ifdef RAM8_STREAMER_CHECKSUM_EN
                    sum_d   = rd_data_i;
`endif
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (ptr_q != PTR_END) begin
                        // Fetch reads the memory before this edge's write lands.
                        dout_d = rd_data_i;
                        ptr_d  = ptr_q + PTR_W'(1);
`ifdef RAM8_STREAMER_CHECKSUM_EN
                        last_d = 1'b0;
                        sum_d  = sum_q + rd_data_i;
`else
                        last_d = (ptr_q == PTR_LST);
`endif
                    end else begin
`ifdef RAM8_STREAMER_CHECKSUM_EN
                        dout_d  = sum_q;
                        last_d  = 1'b1;
                        state_d = S_SUM;
`else
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef RAM8_STREAMER_CHECKSUM_EN
            S_SUM: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ptr_d   = '0;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule : ram8_stream_fsm

`default_nettype wire

// File: rtl/ram8_streamer.sv
// ============================================================================
// Module  : ram8_streamer
// Brief   : Hack-style RAM8 with a start-triggered valid/ready dump port.
//           Optional checksum word: define RAM8_STREAMER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram8_streamer
    import ram8_streamer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in,
    input  logic               load,
    input  logic [ADDR_W-1:0]  address,
    output logic [WIDTH-1:0]   out,
    input  logic               start,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy,
    output logic               done
);

    localparam int DEPTH = DEPTH_DEF;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            mem_q[address] <= in;
        end
    end

    assign out     = mem_q[address];
    assign rd_data = mem_q[rd_addr];

    ram8_stream_fsm #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .dout_ready_i (dout_ready),
        .rd_data_i    (rd_data),
        .rd_addr_o    (rd_addr),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_last_o  (dout_last),
        .busy_o       (busy),
        .done_o       (done)
    );

endmodule : ram8_streamer

`default_nettype wire

// File: tb/tb_ram8_streamer.sv
// ============================================================================
// Module  : tb_ram8_streamer
// Brief   : Directed self-checking bench for ram8_streamer (checksum-aware via
//           RAM8_STREAMER_CHECKSUM_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram8_streamer;

`ifdef RAM8_STREAMER_CHECKSUM_EN
    localparam int NW   = 9;
    localparam int CSUM = 1;
`else
    localparam int NW   = 8;
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tin;
    logic        load;
    logic [2:0]  address;
    logic [15:0] tout;
    logic        start;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        busy;
    logic        done;

    ram8_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .in         (tin),
        .load       (load),
        .address    (address),
        .out        (tout),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] got     [16];
    logic        gotlast [16];
    logic [15:0] expw    [8];
    int          nwords;
    int          ndone;
    int          done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a;
        tin     = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'h1000 + 16'(i));
            expw[i] = 16'h1000 + 16'(i);
        end
    endtask

    // mode 0: plain; 1: writes to addr 5 and 1 mid-dump; 2: start re-pulsed while busy
    task automatic dump(input bit toggle, input int mode);
        nwords   = 0;
        ndone    = 0;
        done_cyc = -1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("start_valid", 32'(dout_valid), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 40; c++) begin
            dout_ready = toggle ? c[0] : 1'b1;
            load  = 1'b0;
            start = 1'b0;
            if (mode == 1 && nwords == 2) begin
                load = 1'b1; address = 3'd5; tin = 16'hBEEF;
            end else if (mode == 1 && nwords == 3) begin
                load = 1'b1; address = 3'd1; tin = 16'h0000;
            end
            if (mode == 2 && nwords == 4) start = 1'b1;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
            if (dout_valid && dout_ready && nwords < 16) begin
                got[nwords]     = dout;
                gotlast[nwords] = dout_last;
                nwords++;
            end
            tick();
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        load       = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;
        if (done_cyc < 0) check("dump_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag, input int exp_cyc);
        logic [15:0] sum;
        sum = 16'h0000;
        check($sformatf("%s_count", tag), 32'(nwords), 32'(NW));
        check($sformatf("%s_done_once", tag), 32'(ndone), 32'd1);
        check($sformatf("%s_cycles", tag), 32'(done_cyc), 32'(exp_cyc));
        for (int i = 0; i < 8; i++) begin
            sum = sum + expw[i];
            check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(expw[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(gotlast[i]),
                  (i == 7 && CSUM == 0) ? 32'd1 : 32'd0);
        end
        if (CSUM == 1) begin
            check($sformatf("%s_csum", tag), 32'(got[8]), 32'(sum));
            check($sformatf("%s_csum_last", tag), 32'(gotlast[8]), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tin = '0; load = 1'b0; address = '0;
        start = 1'b0; dout_ready = 1'b0;
        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(tout), 32'd0);
        reset = 1'b0;
        tick();

        load_pattern();
        address = 3'd3;
        #1;
        check("out_rd3", 32'(tout), 32'h1003);

        dump(1'b0, 0);
        check_stream("full", 8 + CSUM);

        dump(1'b1, 0);
        check_stream("toggle", 16 + 2 * CSUM);

        dump(1'b0, 1);
        expw[5] = 16'hBEEF;
        check_stream("wr_during", 8 + CSUM);
        address = 3'd1;
        #1;
        check("out_after_wr1", 32'(tout), 32'h0000);
        address = 3'd5;
        #1;
        check("out_after_wr5", 32'(tout), 32'hBEEF);

        load_pattern();
        dump(1'b0, 2);
        check_stream("restart_ign", 8 + CSUM);

        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            check($sformatf("abort_out%0d", a), 32'(tout), 32'd0);
        end
        reset = 1'b0;
        dout_ready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) expw[i] = 16'h0000;
        dump(1'b0, 0);
        check_stream("zeros", 8 + CSUM);

        wr(3'd0, 16'hFFFF);
        wr(3'd1, 16'h0002);
        expw[0] = 16'hFFFF;
        expw[1] = 16'h0002;
        dump(1'b0, 0);
        check_stream("wrap", 8 + CSUM);
        if (CSUM == 1) check("wrap_csum_hand", 32'(got[8]), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram8_streamer

`default_nettype wire
